lamp_output_driver: RTL and testbench

//   Output-side counterpart of the sensor input handler. Takes light-state commands from the

---
 rtl/traffic_pkg.sv | 45 ++++
 rtl/lamp_output_driver_flash_gen.sv | 61 ++++++
 rtl/lamp_output_driver.sv | 149 ++++++++++++++
 tb/tb_lamp_output_driver.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
//   Shared types for the traffic-light controller slice.
//   - lamp_state_t : light-state command encodings (RED, YELLOW, GREEN, FLASH)
//   - drv_state_t  : lamp output driver FSM states (HOLD, CLEAR)
//   - lamp_bits_t  : one bit per physical lamp line
//   - lampDecode() : maps a light state (plus flash phase) onto lamp lines
// -----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [1:0] {
        LS_RED    = 2'b00,
        LS_YELLOW = 2'b01,
        LS_GREEN  = 2'b10,
        LS_FLASH  = 2'b11
    } lamp_state_t;

    typedef enum logic [0:0] {
        DRV_HOLD  = 1'b0,
        DRV_CLEAR = 1'b1
    } drv_state_t;

    typedef struct packed {
        logic red;
        logic yellow;
        logic green;
    } lamp_bits_t;

    localparam lamp_bits_t LAMPS_ALL_RED = 3'b100;

    // FLASH only ever drives yellow, and only during its on-phase.
    function automatic lamp_bits_t lampDecode(input lamp_state_t s, input logic flashOn);
        lamp_bits_t b;
        b = '0;
        case (s)
            LS_RED:    b.red    = 1'b1;
            LS_YELLOW: b.yellow = 1'b1;
            LS_GREEN:  b.green  = 1'b1;
            LS_FLASH:  b.yellow = flashOn;
            default:   b.red    = 1'b1;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/lamp_output_driver_flash_gen.sv
// -----------------------------------------------------------------------------
// lamp_flash_gen
//   Phase generator for flashing yellow. Holds a half-period counter and the
//   current phase. Only instantiated when LAMP_FLASH_EN is defined.
// Ports
//   clk       in  clock
//   rst       in  asynchronous active-high reset
//   i_enable  in  the coming cycle is a flashing cycle (advance the phase)
//   i_restart in  the coming cycle is the first flashing cycle (phase ON, count 0)
//   o_phase   out phase for the coming cycle (1 = lamp on), i.e. the value that
//                 gets registered at the next edge, so the caller can register
//                 its lamp output from it without an extra cycle of lag
// -----------------------------------------------------------------------------
module lamp_flash_gen #(
    parameter int FLASH_HALF = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_enable,
    input  logic i_restart,
    output logic o_phase
);

    localparam int CNT_W = (FLASH_HALF > 1) ? $clog2(FLASH_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FLASH_HALF - 1);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cntNext;
    logic             r_phase;
    logic             w_phaseNext;

    // Restart wins over counting; the phase flips after FLASH_HALF cycles.
    always_comb begin
        w_cntNext   = r_cnt;
        w_phaseNext = r_phase;
        if (i_restart) begin
            w_cntNext   = '0;
            w_phaseNext = 1'b1;
        end else if (i_enable) begin
            if (r_cnt == CNT_LAST) begin
                w_cntNext   = '0;
                w_phaseNext = ~r_phase;
            end else begin
                w_cntNext = r_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else begin
            r_cnt   <= w_cntNext;
            r_phase <= w_phaseNext;
        end
    end

    assign o_phase = w_phaseNext;

endmodule

// File: rtl/lamp_output_driver.sv
// -----------------------------------------------------------------------------
// lamp_output_driver
//   Accepts light-state commands from the controller over valid/ready and
//   drives the red/yellow/green lamp lines glitch-free. Every state is shown
//   for at least MIN_HOLD cycles, and every change of state is preceded by
//   CLEAR_TIME cycles of all-red.
// Configuration
//   LAMP_FLASH_EN : when defined, command 11 selects flashing yellow (toggling
//                   every FLASH_HALF cycles). When undefined, command 11 is
//                   treated as RED and no flash logic is built.
// Ports
//   clk, rst       clock, asynchronous active-high reset
//   cmd_valid      controller presents cmd_state
//   cmd_state[1:0] requested light state (see traffic_pkg::lamp_state_t)
//   cmd_ready      command accepted this cycle if cmd_valid is high
//   lamp_red/yellow/green  registered lamp drives
//   busy           clearance running or minimum hold not yet met
// -----------------------------------------------------------------------------
module lamp_output_driver
    import traffic_pkg::*;
#(
    parameter int MIN_HOLD   = 8,
    parameter int CLEAR_TIME = 2,
    parameter int FLASH_HALF = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    input  logic [1:0] cmd_state,
    output logic       cmd_ready,
    output logic       lamp_red,
    output logic       lamp_yellow,
    output logic       lamp_green,
    output logic       busy
);

    localparam int HOLD_W = $clog2(MIN_HOLD + 1);
    localparam int CLR_W  = (CLEAR_TIME > 0) ? $clog2(CLEAR_TIME + 1) : 1;
    localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MIN_HOLD);
    localparam logic [CLR_W-1:0]  CLR_LAST = (CLEAR_TIME > 0) ? CLR_W'(CLEAR_TIME - 1) : '0;

    drv_state_t        r_state;
    drv_state_t        w_stateNext;
    lamp_state_t       r_cur;
    lamp_state_t       w_curNext;
    lamp_state_t       r_nxt;
    lamp_state_t       w_nxtNext;
    lamp_state_t       w_cmdMapped;
    logic [HOLD_W-1:0] r_holdCnt;
    logic [HOLD_W-1:0] w_holdCntNext;
    logic [CLR_W-1:0]  r_clrCnt;
    logic [CLR_W-1:0]  w_clrCntNext;
    logic              w_accept;
    logic              w_flashOn;
    lamp_bits_t        w_lampsNext;

    assign cmd_ready = (r_state == DRV_HOLD) && (r_holdCnt == HOLD_MAX);
    assign busy      = !cmd_ready;
    assign w_accept  = cmd_valid && cmd_ready;

`ifdef LAMP_FLASH_EN
    logic w_flashNextHold;
    logic w_flashNowHold;

    assign w_cmdMapped = lamp_state_t'(cmd_state);

    // The phase restarts only when flashing is entered, so a repeated FLASH
    // command does not disturb the ongoing rhythm.
    assign w_flashNextHold = (w_stateNext == DRV_HOLD) && (w_curNext == LS_FLASH);
    assign w_flashNowHold  = (r_state == DRV_HOLD) && (r_cur == LS_FLASH);

    lamp_flash_gen #(
        .FLASH_HALF (FLASH_HALF)
    ) u_flashGen (
        .clk       (clk),
        .rst       (rst),
        .i_enable  (w_flashNextHold),
        .i_restart (w_flashNextHold && !w_flashNowHold),
        .o_phase   (w_flashOn)
    );
`else
    // Without flash support an unknown request falls back to the safe state.
    assign w_cmdMapped = (cmd_state == 2'b11) ? LS_RED : lamp_state_t'(cmd_state);
    assign w_flashOn   = 1'b0;
`endif

    always_comb begin
        w_stateNext   = r_state;
        w_curNext     = r_cur;
        w_nxtNext     = r_nxt;
        w_holdCntNext = r_holdCnt;
        w_clrCntNext  = r_clrCnt;
        case (r_state)
            DRV_HOLD: begin
                if (r_holdCnt != HOLD_MAX) begin
                    w_holdCntNext = r_holdCnt + 1'b1;
                end
                if (w_accept && (w_cmdMapped != r_cur)) begin
                    if (CLEAR_TIME > 0) begin
                        w_nxtNext    = w_cmdMapped;
                        w_clrCntNext = '0;
                        w_stateNext  = DRV_CLEAR;
                    end else begin
                        w_curNext     = w_cmdMapped;
                        w_holdCntNext = '0;
                    end
                end
            end
            DRV_CLEAR: begin
                if (r_clrCnt == CLR_LAST) begin
                    w_curNext     = r_nxt;
                    w_holdCntNext = '0;
                    w_stateNext   = DRV_HOLD;
                end else begin
                    w_clrCntNext = r_clrCnt + 1'b1;
                end
            end
            default: w_stateNext = DRV_HOLD;
        endcase
    end

    // Lamps are decoded from the next state so the registered outputs line up
    // with the FSM state and never glitch on input changes.
    assign w_lampsNext = (w_stateNext == DRV_CLEAR) ? LAMPS_ALL_RED
                                                    : lampDecode(w_curNext, w_flashOn);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= DRV_HOLD;
            r_cur       <= LS_RED;
            r_nxt       <= LS_RED;
            r_holdCnt   <= '0;
            r_clrCnt    <= '0;
            lamp_red    <= 1'b1;
            lamp_yellow <= 1'b0;
            lamp_green  <= 1'b0;
        end else begin
            r_state     <= w_stateNext;
            r_cur       <= w_curNext;
            r_nxt       <= w_nxtNext;
            r_holdCnt   <= w_holdCntNext;
            r_clrCnt    <= w_clrCntNext;
            lamp_red    <= w_lampsNext.red;
            lamp_yellow <= w_lampsNext.yellow;
            lamp_green  <= w_lampsNext.green;
        end
    end

endmodule

// File: tb/tb_lamp_output_driver.sv
// -----------------------------------------------------------------------------
// tb_lamp_output_driver
//   Self-checking bench for lamp_output_driver. The reference model tracks the
//   driver as a timeline: the edge from which the current target state is
//   shown and the edge from which a new command can be taken. Expected lamps
//   and ready are derived from those two numbers with plain arithmetic.
//   Works with or without LAMP_FLASH_EN defined.
// -----------------------------------------------------------------------------
module tb_lamp_output_driver;

    localparam int MIN_HOLD   = 8;
    localparam int CLEAR_TIME = 2;
    localparam int FLASH_HALF = 16;

    logic       clk;
    logic       rst;
    logic       cmdValid;
    logic [1:0] cmdState;
    logic       cmdReady;
    logic       lampRed;
    logic       lampYellow;
    logic       lampGreen;
    logic       busy;

    int vectors;
    int miscompares;

    // Reference model: edges since reset release, target state, the first
    // edge after which the target is shown, and the first edge after which
    // a command is accepted.
    int edgeCount;
    int modelTgt;
    int showFrom;
    int readyFrom;

    lamp_output_driver #(
        .MIN_HOLD   (MIN_HOLD),
        .CLEAR_TIME (CLEAR_TIME),
        .FLASH_HALF (FLASH_HALF)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .cmd_valid   (cmdValid),
        .cmd_state   (cmdState),
        .cmd_ready   (cmdReady),
        .lamp_red    (lampRed),
        .lamp_yellow (lampYellow),
        .lamp_green  (lampGreen),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Invariants that must hold on every cycle of every test.
    always @(negedge clk) begin
        if (!rst) begin
            assert (($countones({lampRed, lampYellow, lampGreen}) <= 1) && (busy == !cmdReady))
            else $error("[TB] FAIL invariant: lamps=%b ready=%b busy=%b, required at most one lamp and busy==!ready",
                        {lampRed, lampYellow, lampGreen}, cmdReady, busy);
        end
    end

    function automatic int mapCmd(input logic [1:0] c);
`ifdef LAMP_FLASH_EN
        return int'(c);
`else
        return (c == 2'b11) ? 0 : int'(c);
`endif
    endfunction

    // {red, yellow, green, ready, busy} expected after edge k.
    function automatic logic [4:0] expVec(input int k);
        logic [2:0] lamps;
        logic       rdy;
        if (k < showFrom) begin
            lamps = 3'b100;
        end else begin
            case (modelTgt)
                0:       lamps = 3'b100;
                1:       lamps = 3'b010;
                2:       lamps = 3'b001;
                default: lamps = ((((k - showFrom) / FLASH_HALF) % 2) == 0) ? 3'b010 : 3'b000;
            endcase
        end
        rdy = (k >= readyFrom);
        return {lamps, rdy, !rdy};
    endfunction

    // Advances one clock and the model; reports whether a command was taken.
    task automatic tick(output logic accepted);
        logic acc;
        int   mapped;
        acc    = cmdValid && (edgeCount >= readyFrom);
        mapped = mapCmd(cmdState);
        @(posedge clk);
        edgeCount++;
        if (acc && (mapped != modelTgt)) begin
            modelTgt  = mapped;
            showFrom  = edgeCount + CLEAR_TIME;
            readyFrom = showFrom + MIN_HOLD;
        end
        @(negedge clk);
        accepted = acc;
    endtask

    task automatic doReset();
        cmdValid = 1'b0;
        cmdState = 2'b00;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst       = 1'b0;
        edgeCount = 0;
        modelTgt  = 0;
        showFrom  = 0;
        readyFrom = MIN_HOLD;
    endtask

    task automatic test_reset();
        logic acc;
        cmdValid = 1'b0;
        cmdState = 2'b00;
        rst      = 1'b1;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if ({lampRed, lampYellow, lampGreen, cmdReady, busy} !== 5'b10001) begin
            miscompares++;
            $display("[TB] FAIL reset_values: got %b required %b",
                     {lampRed, lampYellow, lampGreen, cmdReady, busy}, 5'b10001);
        end
        doReset();
        for (int i = 0; i < 12; i++) begin
            tick(acc);
            vectors++;
            if ({lampRed, lampYellow, lampGreen, cmdReady, busy} !== expVec(edgeCount)) begin
                miscompares++;
                $display("[TB] FAIL reset_idle edge %0d: got %b required %b", edgeCount,
                         {lampRed, lampYellow, lampGreen, cmdReady, busy}, expVec(edgeCount));
            end
        end
    endtask

    // GREEN from reset, then YELLOW requested early in the green hold.
    task automatic test_green_then_yellow();
        logic acc;
        doReset();
        cmdValid = 1'b1;
        cmdState = 2'b10;
        for (int i = 0; i < 14; i++) begin
            tick(acc);
            if (acc) cmdValid = 1'b0;
            vectors++;
            if ({lampRed, lampYellow, lampGreen, cmdReady, busy} !== expVec(edgeCount)) begin
                miscompares++;
                $display("[TB] FAIL green_from_reset edge %0d: got %b required %b", edgeCount,
                         {lampRed, lampYellow, lampGreen, cmdReady, busy}, expVec(edgeCount));
            end
        end
        cmdValid = 1'b1;
        cmdState = 2'b01;
        for (int i = 0; i < 28; i++) begin
            tick(acc);
            if (acc) cmdValid = 1'b0;
            vectors++;
            if ({lampRed, lampYellow, lampGreen, cmdReady, busy} !== expVec(edgeCount)) begin
                miscompares++;
                $display("[TB] FAIL early_yellow edge %0d: got %b required %b", edgeCount,
                         {lampRed, lampYellow, lampGreen, cmdReady, busy}, expVec(edgeCount));
            end
        end
    endtask

    task automatic test_same_state();
        logic acc;
        doReset();
        for (int i = 0; i < 10; i++) tick(acc);
        cmdValid = 1'b1;
        cmdState = 2'b00;
        for (int i = 0; i < 6; i++) begin
            tick(acc);
            vectors++;
            if ({lampRed, lampYellow, lampGreen, cmdReady, busy} !== expVec(edgeCount)) begin
                miscompares++;
                $display("[TB] FAIL same_state edge %0d: got %b required %b", edgeCount,
                         {lampRed, lampYellow, lampGreen, cmdReady, busy}, expVec(edgeCount));
            end
        end
        cmdValid = 1'b0;
    endtask

    task automatic test_reset_abort();
        logic acc;
        int   guard;
        doReset();
        cmdValid = 1'b1;
        cmdState = 2'b10;
        acc      = 1'b0;
        guard    = 0;
        while (!acc && guard < 30) begin
            tick(acc);
            guard++;
        end
        cmdValid = 1'b0;
        vectors++;
        if (!acc) begin
            miscompares++;
            $display("[TB] FAIL abort_accept_timeout: got no accept required accept within 30 cycles");
        end
        // Mid-clearance: reset asynchronously between edges.
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({lampRed, lampYellow, lampGreen, cmdReady, busy} !== 5'b10001) begin
            miscompares++;
            $display("[TB] FAIL abort_in_clear: got %b required %b",
                     {lampRed, lampYellow, lampGreen, cmdReady, busy}, 5'b10001);
        end
        doReset();
        for (int i = 0; i < 15; i++) begin
            tick(acc);
            vectors++;
            if ({lampRed, lampYellow, lampGreen, cmdReady, busy} !== expVec(edgeCount)) begin
                miscompares++;
                $display("[TB] FAIL after_abort edge %0d: got %b required %b", edgeCount,
                         {lampRed, lampYellow, lampGreen, cmdReady, busy}, expVec(edgeCount));
            end
        end
        // Mid-hold: reset while green is shown.
        cmdValid = 1'b1;
        cmdState = 2'b10;
        for (int i = 0; i < 6; i++) begin
            tick(acc);
            if (acc) cmdValid = 1'b0;
        end
        #2 rst = 1'b1;
        #1;
        vectors++;
        if ({lampRed, lampYellow, lampGreen, cmdReady, busy} !== 5'b10001) begin
            miscompares++;
            $display("[TB] FAIL abort_in_hold: got %b required %b",
                     {lampRed, lampYellow, lampGreen, cmdReady, busy}, 5'b10001);
        end
        doReset();
    endtask

    task automatic test_flash();
        logic acc;
        doReset();
        cmdValid = 1'b1;
        cmdState = 2'b11;
        for (int i = 0; i < 90; i++) begin
            tick(acc);
            if (acc) cmdValid = 1'b0;
            vectors++;
            if ({lampRed, lampYellow, lampGreen, cmdReady, busy} !== expVec(edgeCount)) begin
                miscompares++;
                $display("[TB] FAIL flash edge %0d: got %b required %b", edgeCount,
                         {lampRed, lampYellow, lampGreen, cmdReady, busy}, expVec(edgeCount));
            end
        end
    endtask

    task automatic test_random();
        logic acc;
        doReset();
        for (int i = 0; i < 600; i++) begin
            if (!cmdValid && ($urandom_range(0, 3) == 0)) begin
                cmdValid = 1'b1;
                cmdState = 2'($urandom_range(0, 3));
            end
            tick(acc);
            if (acc) cmdValid = 1'b0;
            vectors++;
            if ({lampRed, lampYellow, lampGreen, cmdReady, busy} !== expVec(edgeCount)) begin
                miscompares++;
                $display("[TB] FAIL random edge %0d: got %b required %b", edgeCount,
                         {lampRed, lampYellow, lampGreen, cmdReady, busy}, expVec(edgeCount));
            end
        end
        cmdValid = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst         = 1'b1;
        cmdValid    = 1'b0;
        cmdState    = 2'b00;
        edgeCount   = 0;
        modelTgt    = 0;
        showFrom    = 0;
        readyFrom   = MIN_HOLD;
        test_reset();
        test_green_then_yellow();
        test_same_state();
        test_reset_abort();
        test_flash();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
